// File: rtl/seq_mul_xlen.sv
// seq_mul_xlen -- multi-cycle RV32M multiplier (MUL, MULH, MULHSU, MULHU).
//
// Radix-2 shift-add on operand magnitudes. One accumulate per cycle through a
// 2*XLEN-bit ripple chain of full_adder_1bit cells. The closing sign fix
// (two's-complement negate) reuses the same chain.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   request valid            o_ready  request accepted (IDLE)
//   i_op      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_rs1     multiplicand             i_rs2    multiplier
//   o_valid   result valid (DONE)      i_ready  consumer takes result
//   o_result  selected result word
//
// Build option: SEQ_MUL_EARLY_EXIT_EN. When defined, CALC ends as soon as the
// remaining multiplier is zero. Results are the same in both builds; only the
// latency changes.

module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_mul_xlen #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);
  localparam int W  = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [1:0]      op;
  logic [W-1:0]    mcand;
  logic [XLEN-1:0] mplier;
  logic [W-1:0]    acc;
  logic [CW-1:0]   count;
  logic            neg;

  // Operand signs and magnitudes at the accept edge. The magnitude of the
  // most negative value wraps back to itself, which is right when it is
  // read as unsigned.
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;

  assign s1   = ((i_op == 2'b01) || (i_op == 2'b10)) & i_rs1[XLEN-1];
  assign s2   = (i_op == 2'b01) & i_rs2[XLEN-1];
  assign mag1 = s1 ? (~i_rs1 + XLEN'(1)) : i_rs1;
  assign mag2 = s2 ? (~i_rs2 + XLEN'(1)) : i_rs2;

  // Shared adder. CALC computes acc + mcand. FIX computes ~acc + 0 + 1.
  logic [W-1:0] add_a, add_b, sum;
  logic [W:0]   carry;
  logic         carry_unused;

  assign add_a    = (state == FIX) ? ~acc : acc;
  assign add_b    = (state == FIX) ? '0 : mcand;
  assign carry[0] = (state == FIX);

  for (genvar g = 0; g < W; g++) begin : g_fa
    full_adder_1bit u_fa (
      .a  (add_a[g]),
      .b  (add_b[g]),
      .ci (carry[g]),
      .s  (sum[g]),
      .co (carry[g+1])
    );
  end

  // The product is taken modulo 2^W, so the final carry is dropped.
  assign carry_unused = carry[W];

  logic [W-1:0] fix_val;
  assign fix_val = neg ? sum : acc;

  // Decides when CALC ends. The test comes before any iteration, so a CALC
  // cycle either iterates or hands over to FIX.
  logic calc_end;
`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign calc_end = (count == CW'(XLEN)) || (mplier == '0);
`else
  assign calc_end = (count == CW'(XLEN));
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      op       <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      neg      <= 1'b0;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            op      <= i_op;
            mcand   <= {{XLEN{1'b0}}, mag1};
            mplier  <= mag2;
            acc     <= '0;
            count   <= '0;
            neg     <= s1 ^ s2;
            o_ready <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (calc_end) begin
            state <= FIX;
          end else begin
            if (mplier[0]) acc <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
          end
        end
        FIX: begin
          acc      <= fix_val;
          o_result <= (op == 2'b00) ? fix_val[XLEN-1:0] : fix_val[W-1:XLEN];
          o_valid  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_xlen.sv
module tb_seq_mul_xlen;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  seq_mul_xlen #(.XLEN(32)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  // Expected latency: the early-exit figure when that build is selected,
  // otherwise the fixed XLEN+2.
  function automatic int lat(input int ee_lat);
    return EE ? ee_lat : 34;
  endfunction

  // Waits for o_valid after an accept edge and returns the cycle it appeared.
  task automatic wait_valid(input string tag, output int cyc);
    bit rdy_seen;
    cyc = 0;
    rdy_seen = 1'b0;
    while (!o_valid && cyc < 100) begin
      step;
      cyc++;
      if (o_ready) rdy_seen = 1'b1;
    end
    check({tag, ".busy_rdy"}, rdy_seen, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit tog);
    int cyc;
    bit rdy_seen;
    i_op = op; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
    check({tag, ".rdy"}, o_ready, 1'b1);
    step;                       // accept edge = cycle 0
    i_valid = 1'b0;
    cyc = 0;
    rdy_seen = 1'b0;
    while (!o_valid && cyc < 100) begin
      if (tog) begin
        i_rs1 = $urandom; i_rs2 = $urandom; i_op = 2'($urandom_range(0, 3));
      end
      step;
      cyc++;
      if (o_ready) rdy_seen = 1'b1;
    end
    check({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".res"}, o_result, exp);
    check({tag, ".busy_rdy"}, rdy_seen, 1'b0);
    i_ready = 1'b1;
    step;
    i_ready = 1'b0;
    check({tag, ".vld_drop"}, o_valid, 1'b0);
  endtask

  initial begin
    int cyc;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_op = 2'b00; i_rs1 = '0; i_rs2 = '0;
    step; step;
    check("rst.rdy", o_ready, 1'b1);
    check("rst.vld", o_valid, 1'b0);
    check("rst.res", o_result, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step;

    run_op("mul_7xm3", 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, lat(34), 1'b0);
    run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, lat(34), 1'b0);
    run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat(34), 1'b0);
    run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat(34), 1'b0);
    run_op("mul_toggle", 2'b00, 32'd100, 32'd200, 32'd20000, lat(10), 1'b1);
    run_op("mul_9x2", 2'b00, 32'd9, 32'd2, 32'd18, lat(4), 1'b0);
    run_op("mul_5x0", 2'b00, 32'd5, 32'd0, 32'd0, lat(2), 1'b0);
    run_op("mulh_m1m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, lat(3), 1'b0);
    run_op("mulh_m5x3", 2'b01, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, lat(4), 1'b0);

    // Backpressure: result held 5 cycles while a new request waits on i_valid.
    i_op = 2'b00; i_rs1 = 32'h1234; i_rs2 = 32'h10; i_valid = 1'b1;
    step;
    i_op = 2'b00; i_rs1 = 32'd6; i_rs2 = 32'd7;   // next request, held throughout
    wait_valid("bp", cyc);
    check("bp.lat", 64'(cyc), 64'(lat(7)));
    for (int k = 0; k < 5; k++) begin
      check("bp.hold_vld", o_valid, 1'b1);
      check("bp.hold_res", o_result, 32'h0001_2340);
      check("bp.hold_rdy", o_ready, 1'b0);
      step;
    end
    i_ready = 1'b1;
    step;                        // handshake edge
    i_ready = 1'b0;
    check("bp.idle_rdy", o_ready, 1'b1);
    check("bp.idle_vld", o_valid, 1'b0);
    step;                        // queued request accepted here
    i_valid = 1'b0;
    check("bp.acc_rdy", o_ready, 1'b0);
    wait_valid("bp2", cyc);
    check("bp2.lat", 64'(cyc), 64'(lat(5)));
    check("bp2.res", o_result, 32'd42);
    i_ready = 1'b1;
    step;
    i_ready = 1'b0;

    // Reset in CALC aborts the operation; outputs go to reset values at once.
    i_op = 2'b11; i_rs1 = 32'hFFFF_FFFF; i_rs2 = 32'hFFFF_FFFF; i_valid = 1'b1;
    step;
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) step;
    check("rstc.busy", o_ready, 1'b0);
    i_rst_n = 1'b0;
    #1;
    check("rstc.vld", o_valid, 1'b0);
    check("rstc.rdy", o_ready, 1'b1);
    check("rstc.res", o_result, 32'h0);
    step;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step;
    check("rstc.no_res", o_valid, 1'b0);
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15, lat(5), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
